// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
//   UART transmitter. Serialises one parallel word per frame:
//   start bit (0), DATA_WIDTH data bits LSB first, optional parity bit,
//   stop bit(s) (1). The block runs on the baud-rate clock, so each frame
//   bit occupies exactly one clk cycle.
//
//   The parity convention matches the RX parity checker:
//     par_typ = 0 -> even parity (total number of ones incl. parity is even)
//     par_typ = 1 -> odd parity
//
// Configuration macro:
//   UART_TX_TWO_STOP_EN - when defined, the stop phase lasts two cycles
//                         (two stop bits). When undefined, one stop bit.
//
// Ports:
//   clk        in   baud-rate clock, rising edge
//   rst        in   asynchronous reset, active low
//   p_data     in   word to send, sampled together with data_valid
//   data_valid in   frame request, only accepted while busy = 0
//   par_en     in   1 = append a parity bit, sampled with data_valid
//   par_typ    in   0 = even, 1 = odd, sampled with data_valid
//   tx_out     out  serial line (registered), idles at 1
//   busy       out  registered, 1 while a frame is on the line
// ---------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    // Counter holds values 0..DATA_WIDTH, so it needs one bit more than
    // clog2(DATA_WIDTH); it never wraps inside a frame.
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state_q,  state_d;
    logic [DATA_WIDTH-1:0]   shreg_q,  shreg_d;
    logic [CW-1:0]           cnt_q,    cnt_d;
    logic                    par_en_q, par_en_d;
    logic                    parity_q, parity_d;
    logic                    tx_q,     tx_d;
    logic                    busy_q,   busy_d;
`ifdef UART_TX_TWO_STOP_EN
    // Marks that the first of the two stop cycles has already been spent.
    logic                    stop2_q,  stop2_d;
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            par_en_q <= 1'b0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            par_en_q <= par_en_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q  <= stop2_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic. tx_out and busy are registered, so
    // every value computed here appears on the pins one edge later; each
    // state therefore loads the line value of the *following* state.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        par_en_d = par_en_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
`ifdef UART_TX_TWO_STOP_EN
        stop2_d  = stop2_q;
`endif

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (data_valid) begin
                    // Everything the frame needs is captured here so later
                    // input changes cannot disturb the frame in flight.
                    shreg_d  = p_data;
                    par_en_d = par_en;
                    parity_d = par_typ ? ~^p_data : ^p_data;
                    cnt_d    = '0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = START;
                end
            end

            START: begin
                tx_d    = shreg_q[0];
                shreg_d = shreg_q >> 1;
                cnt_d   = CW'(1);
                state_d = DATA;
            end

            DATA: begin
                // cnt_q counts data bits already driven onto the line.
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (par_en_q) begin
                        tx_d    = parity_q;
                        state_d = PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end
                end else begin
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end

            PARITY: begin
                tx_d    = 1'b1;
                state_d = STOP;
            end

            STOP: begin
                tx_d = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                if (!stop2_q) begin
                    stop2_d = 1'b1;
                end else begin
                    stop2_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
`else
                busy_d  = 1'b0;
                state_d = IDLE;
`endif
            end

            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
//   Self-checking bench for uart_tx_frame. A reference model keeps the
//   expected line contents as a queue of bits: an accepted request appends a
//   whole frame, every clock edge consumes one bit, and an empty queue means
//   idle (line 1, busy 0). tx_out and busy are compared on every falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

    localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] p_data = '0;
    logic          data_valid = 1'b0;
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic          tx_out;
    logic          busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit mq[$];
    bit was_busy;

    function automatic void push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
        int ones;
        ones = 0;
        mq.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            mq.push_back(d[i]);
            ones += int'(d[i]);
        end
        // Even: parity bit makes the total count of ones even; odd: odd.
        if (pe) mq.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
        for (int i = 0; i < NSTOP; i++) mq.push_back(1'b1);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
        end else begin
            was_busy = (mq.size() != 0);
            if (was_busy) void'(mq.pop_front());
            if (!was_busy && data_valid) push_frame(p_data, par_en, par_typ);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("tx_line", {31'd0, tx_out}, {31'd0, (mq.size() != 0) ? mq[0] : 1'b1});
            chk("busy", {31'd0, busy}, {31'd0, mq.size() != 0});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Sends one frame, scrambles the inputs mid-frame, measures busy length
    // and optionally checks the parity bit against a known constant.
    task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                              input int exp_par);
        int n;
        logic [15:0] bits;
        wait_idle();
        data_valid = 1'b1; p_data = d; par_en = pe; par_typ = pt;
        @(negedge clk);
        data_valid = 1'b0;
        p_data = DW'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
        n = 0;
        bits = '0;
        while (busy && n < 16) begin
            bits[n] = tx_out;
            n++;
            @(negedge clk);
        end
        chk("busy_len", 32'(n), 32'(2 + DW + int'(pe) + NSTOP - 1));
        if (pe) chk("parity_bit", {31'd0, bits[DW+1]}, 32'(exp_par));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst_tx", {31'd0, tx_out}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Known vectors
        send_frame(8'hA5, 1'b0, 1'b0, 0);
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        send_frame(8'h07, 1'b1, 1'b1, 0);
        send_frame(8'h03, 1'b1, 1'b1, 1);
        send_frame(8'h00, 1'b0, 1'b0, 0);

        // Request during DATA of a 0xFF frame must be dropped.
        wait_idle();
        data_valid = 1'b1; p_data = 8'hFF; par_en = 1'b0; par_typ = 1'b0;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        data_valid = 1'b1; p_data = 8'h3C; par_en = 1'b1;
        repeat (2) @(negedge clk);
        data_valid = 1'b0;
        wait_idle();

        // Async reset in the 4th data cycle, then a clean frame.
        data_valid = 1'b1; p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_tx", {31'd0, tx_out}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b1, 1);

        // Random traffic: requests arrive at any time, including while busy.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            data_valid = ($urandom_range(0, 3) == 0);
            p_data     = DW'($urandom);
            par_en     = 1'($urandom);
            par_typ    = 1'($urandom);
        end
        data_valid = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
